// File: rtl/mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux4_rr_arbiter
// Purpose  : Round-robin arbiter and sequencer for a shared 4:1 mux datapath.
//            One of four requesters is granted at a time. The grant holds
//            while the owner keeps requesting, for at most MAX_HOLD cycles.
//            The priority pointer then rotates past the released requester.
//            The selected word is registered onto y with a valid flag.
// Ports    : clk   - clock; all state changes on the rising edge
//            rst   - synchronous, active-high reset
//            req   - request lines, req[i] belongs to requester i
//            a     - packed requester data, word i is a[i*DW +: DW]
//            gnt   - registered one-hot grant (zero when idle)
//            sel   - registered mux select, current or most recent grant
//            busy  - high while a grant is active
//            y     - registered selected data word
//            y_vld - y holds a word transferred in the previous cycle
// Revision : 1.0 - initial release
// ============================================================================
module mux4_rr_arbiter #(
    parameter int DW       = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      req,
    input  logic [4*DW-1:0] a,
    output logic [3:0]      gnt,
    output logic [1:0]      sel,
    output logic            busy,
    output logic [DW-1:0]   y,
    output logic            y_vld
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

    // Last granted-cycle index of a burst; reaching it forces a release.
    localparam logic [3:0] c_hold_last = 4'(MAX_HOLD - 1);

    logic [0:0]    r_state;
    logic [3:0]    r_gnt;
    logic [1:0]    r_sel;
    logic [1:0]    r_last;
    logic [3:0]    r_hold_cnt;
    logic [DW-1:0] r_y;
    logic          r_y_vld;

    logic [DW-1:0] w_words [4];
    logic [1:0]    w_winner;
    logic          w_found;
    logic          w_busy;
    logic          w_xfer;

    // Unpack the data bus so the mux is a plain array index.
    for (genvar gi = 0; gi < 4; gi++) begin : g_words
        assign w_words[gi] = a[gi*DW +: DW];
    end

    // Search starts just after the last released requester and wraps
    // around so that requester is considered last.
    always_comb begin
        logic [1:0] v_idx;
        w_found  = 1'b0;
        w_winner = r_last;
        v_idx    = '0;
        for (int k = 1; k <= 4; k++) begin
            v_idx = r_last + 2'(k);
            if (!w_found && req[v_idx]) begin
                w_found  = 1'b1;
                w_winner = v_idx;
            end
        end
    end

    assign w_busy = (r_state == S_GRANT);
    // While granted, gnt[sel] is always set, so this is the transfer condition.
    assign w_xfer = w_busy & req[r_sel];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_gnt      <= 4'b0000;
            r_sel      <= 2'd0;
            r_last     <= 2'd3;
            r_hold_cnt <= 4'd0;
            r_y        <= '0;
            r_y_vld    <= 1'b0;
        end else begin
            r_y_vld <= w_xfer;
            if (w_xfer) begin
                r_y <= w_words[r_sel];
            end

            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_gnt      <= 4'b0001 << w_winner;
                        r_sel      <= w_winner;
                        r_hold_cnt <= 4'd0;
                        r_state    <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    // sel is left alone on release so it still names the
                    // most recent grant while idle.
                    if (!req[r_sel] || (r_hold_cnt == c_hold_last)) begin
                        r_gnt      <= 4'b0000;
                        r_last     <= r_sel;
                        r_hold_cnt <= 4'd0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 4'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_gnt   <= 4'b0000;
                end
            endcase
        end
    end

    assign gnt   = r_gnt;
    assign sel   = r_sel;
    assign busy  = w_busy;
    assign y     = r_y;
    assign y_vld = r_y_vld;

endmodule
`default_nettype wire

// File: tb/tb_mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux4_rr_arbiter
// Purpose  : Directed bench for mux4_rr_arbiter. Each cycle's request
//            pattern is paired with the hand-derived grant and select.
//            Granted cycles with a live request queue the expected word.
//            A monitor retires queued words when y_vld appears one cycle
//            later. A second instance covers MAX_HOLD = 1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux4_rr_arbiter;

    localparam int DW = 8;

    logic          clk;
    logic          rst;
    logic [3:0]    req;
    logic [4*DW-1:0] a;
    logic [3:0]    gnt;
    logic [1:0]    sel;
    logic          busy;
    logic [DW-1:0] y;
    logic          y_vld;

    logic [3:0]    req1;
    logic [3:0]    gnt1;
    logic [1:0]    sel1;
    logic          busy1;
    logic [DW-1:0] y1;
    logic          y_vld1;

    typedef struct {
        int          due;
        logic [7:0]  d;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] c_word [4];
    int         total;
    int         bad;
    int         cyc;

    mux4_rr_arbiter #(.DW(DW), .MAX_HOLD(4)) dut (
        .clk(clk), .rst(rst), .req(req), .a(a),
        .gnt(gnt), .sel(sel), .busy(busy), .y(y), .y_vld(y_vld)
    );

    mux4_rr_arbiter #(.DW(DW), .MAX_HOLD(1)) dut1 (
        .clk(clk), .rst(rst), .req(req1), .a(a),
        .gnt(gnt1), .sel(sel1), .busy(busy1), .y(y1), .y_vld(y_vld1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Check this cycle's outputs, then drive the inputs sampled at the edge
    // that ends this cycle. A granted cycle whose owner still requests is a
    // transfer, so its word is due on y in the next cycle.
    task automatic vec(input logic v_rst, input logic [3:0] r,
                       input logic [3:0] eg, input logic [1:0] es);
        @(negedge clk);
        chk("gnt", gnt, eg);
        chk("sel", sel, es);
        chk("busy", busy, (eg != 4'b0000));
        if (!v_rst && ((eg & r) != 4'b0000)) begin
            exp_t e;
            e.due = cyc + 1;
            e.d   = c_word[es];
            sb_q.push_back(e);
        end
        rst = v_rst;
        req = r;
    endtask

    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].due < cyc) begin
            chk("y_vld_late", 0, 1);
            void'(sb_q.pop_front());
        end
        if (y_vld) begin
            if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
                chk("y", y, sb_q[0].d);
                void'(sb_q.pop_front());
            end else begin
                chk("y_vld_spurious", y_vld, 0);
            end
        end else if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
            chk("y_vld_missing", y_vld, 1);
            void'(sb_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] e_g1 [8];
        logic [1:0] e_s1 [8];
        total     = 0;
        bad       = 0;
        cyc       = 0;
        c_word[0] = 8'h11;
        c_word[1] = 8'h22;
        c_word[2] = 8'h33;
        c_word[3] = 8'h44;
        a    = {8'h44, 8'h33, 8'h22, 8'h11};
        rst  = 1'b1;
        req  = 4'b0000;
        req1 = 4'b0000;
        @(posedge clk);

        // Reset held for two edges; outputs must show reset values.
        vec(1'b1, 4'b0000, 4'b0000, 2'd0);
        chk("y_rst", y, 8'h00);
        chk("y_vld_rst", y_vld, 0);

        // Priority from reset and the 4-cycle hold limit with all requesting.
        vec(1'b0, 4'b1111, 4'b0000, 2'd0);
        for (int i = 0; i < 4; i++) begin
            repeat (4) vec(1'b0, 4'b1111, 4'b0001 << i, 2'(i));
            vec(1'b0, 4'b1111, 4'b0000, 2'(i));
        end
        vec(1'b0, 4'b0000, 4'b0001, 2'd0);   // back to 0, then drop
        // Data path: requester 2 alone, two transfers of 8'h33.
        vec(1'b0, 4'b0100, 4'b0000, 2'd0);
        vec(1'b0, 4'b0100, 4'b0100, 2'd2);
        vec(1'b0, 4'b0100, 4'b0100, 2'd2);
        vec(1'b0, 4'b0000, 4'b0100, 2'd2);
        // Early release of requester 1 while requester 3 waits.
        vec(1'b0, 4'b0010, 4'b0000, 2'd2);
        vec(1'b0, 4'b1010, 4'b0010, 2'd1);
        vec(1'b0, 4'b1010, 4'b0010, 2'd1);
        vec(1'b0, 4'b1000, 4'b0010, 2'd1);   // drop cycle, no transfer
        vec(1'b0, 4'b1000, 4'b0000, 2'd1);
        vec(1'b0, 4'b1000, 4'b1000, 2'd3);
        vec(1'b0, 4'b0000, 4'b1000, 2'd3);
        // Rotation: park the pointer on 1, then only 0 requests.
        vec(1'b0, 4'b0010, 4'b0000, 2'd3);
        vec(1'b0, 4'b0000, 4'b0010, 2'd1);
        vec(1'b0, 4'b0001, 4'b0000, 2'd1);
        vec(1'b0, 4'b0000, 4'b0001, 2'd0);
        // Pointer on 0: 3 is searched before 0.
        vec(1'b0, 4'b1001, 4'b0000, 2'd0);
        vec(1'b0, 4'b0000, 4'b1000, 2'd3);
        // Reset in the second cycle of a grant to requester 2.
        vec(1'b0, 4'b0100, 4'b0000, 2'd3);
        vec(1'b0, 4'b0100, 4'b0100, 2'd2);
        vec(1'b1, 4'b0100, 4'b0100, 2'd2);
        vec(1'b0, 4'b1111, 4'b0000, 2'd0);
        chk("y_after_rst", y, 8'h00);
        chk("y_vld_after_rst", y_vld, 0);
        vec(1'b0, 4'b0000, 4'b0001, 2'd0);
        vec(1'b0, 4'b0000, 4'b0000, 2'd0);

        // MAX_HOLD = 1 instance: grants alternate with an idle cycle.
        e_g1 = '{4'b0000, 4'b0001, 4'b0000, 4'b0010,
                 4'b0000, 4'b0001, 4'b0000, 4'b0010};
        e_s1 = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd0, 2'd1};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("gnt_h1", gnt1, e_g1[i]);
            chk("sel_h1", sel1, e_s1[i]);
            req1 = 4'b0011;
        end
        req1 = 4'b0000;

        repeat (3) @(negedge clk);
        chk("sb_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
